// File: rtl/darkriscv_wb_bridge.sv
// darkriscv native bus to Wishbone B4 master bridge.
// One outstanding access, optional response pipeline and timeout.
module darkriscv_wb_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int PIPELINED      = 1,
  parameter int RESP_STAGES    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_core,
  input  logic              rst_core,
  input  logic              core_rd_i,
  input  logic              core_wr_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  input  logic [DATA_W/8-1:0] core_be_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_ack_o,
  output logic              core_err_o,
  output logic              core_busy_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_stall_i
);

  localparam int SW = DATA_W / 8;
  localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (CLOG > 8) ? CLOG : 8;
  localparam int TO_M1 =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_M1);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_t;

  state_t state, state_nxt;

  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [SW-1:0]     sel_q;
  logic [CW-1:0]     tmo_cnt;

  logic              req;
  logic              active;
  logic              wb_any;
  logic              hit;
  logic              tmo;
  logic              done;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_dat;
  logic              out_vld;
  logic              out_err;
  logic [DATA_W-1:0] out_dat;

  assign req    = core_rd_i | core_wr_i;
  assign active = (state == REQ) || (state == WAIT);
  assign wb_any = wb_ack_i | wb_err_i;

  // Completion: slave answer, or timeout when the slave stays silent.
  // A stalled pipelined strobe has not been taken, so its ack is ignored.
  always_comb begin
    hit = 1'b0;
    if (state == REQ)
      hit = wb_any && ((PIPELINED == 0) || !wb_stall_i);
    else if (state == WAIT)
      hit = wb_any;
    tmo = (TIMEOUT_CYCLES != 0) && active && !hit &&
          (tmo_cnt == TO_LAST);
    done    = (hit | tmo) & ~rst_core;
    rsp_err = tmo | (hit & wb_err_i);
    rsp_dat = (done && !rsp_err && !we_q) ? wb_dat_i : '0;
  end

  // State register.
  always_ff @(posedge clk_core) begin
    if (rst_core) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req) state_nxt = REQ;
      REQ: begin
        if (done)
          state_nxt = (RESP_STAGES == 0) ? IDLE : RESP;
        else if ((PIPELINED != 0) && !wb_stall_i)
          state_nxt = WAIT;
      end
      WAIT: if (done)
        state_nxt = (RESP_STAGES == 0) ? IDLE : RESP;
      RESP: if (out_vld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus and core status outputs decoded from the state.
  always_comb begin
    wb_cyc_o    = active;
    wb_stb_o    = (state == REQ);
    core_busy_o = (state != IDLE);
    wb_we_o     = we_q;
    wb_adr_o    = adr_q;
    wb_dat_o    = dat_q;
    wb_sel_o    = sel_q;
  end

  // Capture the request once; later changes while busy are ignored.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
    end else if (state == IDLE && req) begin
      we_q  <= core_wr_i;
      adr_q <= core_addr_i;
      dat_q <= core_wdata_i;
      sel_q <= core_be_i;
    end
  end

  // Cycles spent on the bus, restarted for every new access.
  always_ff @(posedge clk_core) begin
    if (rst_core)
      tmo_cnt <= '0;
    else if (state == IDLE)
      tmo_cnt <= '0;
    else if (active)
      tmo_cnt <= tmo_cnt + CW'(1);
  end

  generate
    if (RESP_STAGES == 0) begin : g_pass
      assign out_vld = done;
      assign out_err = rsp_err & done;
      assign out_dat = rsp_dat;
    end else begin : g_pipe
      logic [RESP_STAGES-1:0] v_q;
      logic [RESP_STAGES-1:0] e_q;
      logic [DATA_W-1:0]      d_q [RESP_STAGES];

      // Response delay line; bubbles carry zero data and no error.
      always_ff @(posedge clk_core) begin
        if (rst_core) begin
          v_q <= '0;
          e_q <= '0;
          for (int i = 0; i < RESP_STAGES; i++)
            d_q[i] <= '0;
        end else begin
          v_q[0] <= done;
          e_q[0] <= rsp_err & done;
          d_q[0] <= rsp_dat;
          for (int i = 1; i < RESP_STAGES; i++) begin
            v_q[i] <= v_q[i-1];
            e_q[i] <= e_q[i-1];
            d_q[i] <= d_q[i-1];
          end
        end
      end

      assign out_vld = v_q[RESP_STAGES-1];
      assign out_err = e_q[RESP_STAGES-1];
      assign out_dat = d_q[RESP_STAGES-1];
    end
  endgenerate

  // Core response, qualified so data and error are 0 outside ack.
  always_comb begin
    core_ack_o   = out_vld;
    core_err_o   = out_vld & out_err;
    core_rdata_o = out_vld ? out_dat : '0;
  end

endmodule

// File: tb/tb_darkriscv_wb_bridge.sv
// Directed bench for darkriscv_wb_bridge.
// Three instances: pipelined/1 stage, classic/0 stages, pipelined/2 stages/timeout 4.
module tb_darkriscv_wb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [31:0] addr, wdata, dat_i;
  logic [3:0]  be;
  logic        ack_i, err_i, stall_i;

  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic        busy  [3];
  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic [3:0]  sel   [3];
  logic [31:0] adr   [3];
  logic [31:0] dat   [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    darkriscv_wb_bridge #(
      .ADDR_W        (32),
      .DATA_W        (32),
      .PIPELINED     ((g == 1) ? 0 : 1),
      .RESP_STAGES   ((g == 0) ? 1 : ((g == 1) ? 0 : 2)),
      .TIMEOUT_CYCLES((g == 2) ? 4 : 255)
    ) u_dut (
      .clk_core    (clk),
      .rst_core    (rst),
      .core_rd_i   (rd),
      .core_wr_i   (wr),
      .core_addr_i (addr),
      .core_wdata_i(wdata),
      .core_be_i   (be),
      .core_rdata_o(rdata[g]),
      .core_ack_o  (ack[g]),
      .core_err_o  (err[g]),
      .core_busy_o (busy[g]),
      .wb_cyc_o    (cyc[g]),
      .wb_stb_o    (stb[g]),
      .wb_we_o     (we[g]),
      .wb_sel_o    (sel[g]),
      .wb_adr_o    (adr[g]),
      .wb_dat_o    (dat[g]),
      .wb_dat_i    (dat_i),
      .wb_ack_i    (ack_i),
      .wb_err_i    (err_i),
      .wb_stall_i  (stall_i)
    );
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd = 0; wr = 0;
    addr = 0; wdata = 0; be = 0;
    dat_i = 0; ack_i = 0; err_i = 0; stall_i = 0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_cyc",   cyc[i],   0);
      chk("rst_stb",   stb[i],   0);
      chk("rst_ack",   ack[i],   0);
      chk("rst_busy",  busy[i],  0);
      chk("rst_rdata", rdata[i], 0);
      chk("rst_adr",   adr[i],   0);
    end
    rst = 1'b0;

    // pipelined read, ack two cycles after stb
    rst_pulse();
    rd = 1; addr = 32'h40;
    tick();
    chk("t1_stb", stb[0], 1);
    chk("t1_adr", adr[0], 32'h40);
    chk("t1_we",  we[0],  0);
    rd = 0;
    tick();
    chk("t1_stb_drop", stb[0], 0);
    chk("t1_cyc",      cyc[0], 1);
    tick();
    ack_i = 1; dat_i = 32'hDEADBEEF;
    chk("t1_no_early", ack[0], 0);
    tick();
    ack_i = 0;
    chk("t1_ack",   ack[0],   1);
    chk("t1_rdata", rdata[0], 32'hDEADBEEF);
    chk("t1_err",   err[0],   0);
    chk("t1_cyc0",  cyc[0],   0);
    tick();
    chk("t1_ack_one",  ack[0],   0);
    chk("t1_rdata_q",  rdata[0], 0);
    chk("t1_busy_low", busy[0],  0);

    // pipelined write held off by three stall cycles
    rst_pulse();
    wr = 1; addr = 32'h100; wdata = 32'h12345678;
    be = 4'b0011; stall_i = 1;
    tick();
    wr = 0; addr = 32'h200; wdata = 32'hFFFFFFFF; be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      chk("t2_stb", stb[0], 1);
      chk("t2_adr", adr[0], 32'h100);
      chk("t2_dat", dat[0], 32'h12345678);
      chk("t2_sel", sel[0], 32'h3);
      stall_i = (i < 3);
      tick();
    end
    chk("t2_stb_drop", stb[0], 0);
    chk("t2_cyc",      cyc[0], 1);
    chk("t2_we",       we[0],  1);
    ack_i = 1;
    tick();
    ack_i = 0;
    chk("t2_ack",   ack[0],   1);
    chk("t2_rdata", rdata[0], 0);
    chk("t2_err",   err[0],   0);
    tick();
    chk("t2_busy_low", busy[0], 0);
    chk("t2_adr_keep", adr[0],  32'h100);

    // classic, no response stages, held request back-to-back
    rst_pulse();
    rd = 1; addr = 32'h8;
    tick();
    chk("t3_stb",    stb[1], 1);
    chk("t3_no_ack", ack[1], 0);
    tick();
    ack_i = 1; dat_i = 32'hCAFEF00D;
    #1;
    chk("t3_stb_hold", stb[1],   1);
    chk("t3_ack",      ack[1],   1);
    chk("t3_rdata",    rdata[1], 32'hCAFEF00D);
    chk("t3_busy",     busy[1],  1);
    tick();
    ack_i = 0;
    #1;
    chk("t3_cyc0",     cyc[1],  0);
    chk("t3_ack_one",  ack[1],  0);
    chk("t3_busy_low", busy[1], 0);
    tick();
    chk("t3_next_cyc", cyc[1], 1);
    chk("t3_next_stb", stb[1], 1);
    rd = 0;

    // timeout of 4 cycles, two response stages, late ack
    rst_pulse();
    rd = 1; addr = 32'h44;
    tick();
    rd = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_cyc",    cyc[2], 1);
      chk("t4_no_ack", ack[2], 0);
      tick();
    end
    chk("t4_cyc_drop", cyc[2],  0);
    chk("t4_ack_wait", ack[2],  0);
    chk("t4_busy",     busy[2], 1);
    ack_i = 1;
    tick();
    chk("t4_ack",   ack[2],   1);
    chk("t4_err",   err[2],   1);
    chk("t4_rdata", rdata[2], 0);
    tick();
    chk("t4_ack_one",  ack[2],  0);
    chk("t4_busy_low", busy[2], 0);
    tick();
    chk("t4_late_ack", ack[2], 0);
    chk("t4_late_cyc", cyc[2], 0);
    ack_i = 0;

    // simultaneous ack and err
    rst_pulse();
    rd = 1; addr = 32'h10;
    tick();
    rd = 0; ack_i = 1; err_i = 1; dat_i = 32'h55AA55AA;
    #1;
    chk("t5_cl_ack", ack[1], 1);
    chk("t5_cl_err", err[1], 1);
    chk("t5_pl_wait", ack[0], 0);
    tick();
    ack_i = 0; err_i = 0;
    chk("t5_ack",   ack[0],   1);
    chk("t5_err",   err[0],   1);
    chk("t5_rdata", rdata[0], 0);
    tick();
    chk("t5_ack_one", ack[0],  0);
    chk("t5_err_q",   err[0],  0);
    chk("t5_idle",    busy[0], 0);

    // reset while waiting for the slave
    rst_pulse();
    rd = 1; addr = 32'h20;
    tick();
    rd = 0;
    tick();
    chk("t6_wait_cyc", cyc[0], 1);
    chk("t6_wait_stb", stb[0], 0);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_cyc",  cyc[0],  0);
    chk("t6_stb",  stb[0],  0);
    chk("t6_busy", busy[0], 0);
    ack_i = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_ack", ack[0], 0);
      tick();
    end
    ack_i = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
